// File: rtl/decode_stage_param_if.sv
// Decode-stage bus: fetch/hazard/writeback inputs and decode outputs of the MiniMIPS D stage.
// The slave modport is the decode stage itself; master is the surrounding pipeline.
interface decode_stage_param_if #(
  parameter int DATA_WIDTH = 32
);
  logic [31:0]           InstrF;
  logic [DATA_WIDTH-1:0] PCPlus4F;
  logic                  StallD;
  logic                  FlushD;
  logic                  RegWriteW;
  logic [4:0]            WriteRegW;
  logic [DATA_WIDTH-1:0] ResultW;
  logic [DATA_WIDTH-1:0] ALUOutM;
  logic [1:0]            ForwardAD;
  logic [1:0]            ForwardBD;

  logic [31:0]           InstrD;
  logic [DATA_WIDTH-1:0] PCPlus4D;
  logic                  ValidD;
  logic [4:0]            RsD;
  logic [4:0]            RtD;
  logic [4:0]            RdD;
  logic [DATA_WIDTH-1:0] RD1_D;
  logic [DATA_WIDTH-1:0] RD2_D;
  logic [DATA_WIDTH-1:0] ImmD;
  logic [DATA_WIDTH-1:0] PCBranchD;
  logic [DATA_WIDTH-1:0] PCJumpD;
  logic                  EqualD;
  logic                  BranchTakenD;

  modport master (
    output InstrF, PCPlus4F, StallD, FlushD, RegWriteW, WriteRegW, ResultW,
           ALUOutM, ForwardAD, ForwardBD,
    input  InstrD, PCPlus4D, ValidD, RsD, RtD, RdD, RD1_D, RD2_D, ImmD,
           PCBranchD, PCJumpD, EqualD, BranchTakenD
  );

  modport slave (
    input  InstrF, PCPlus4F, StallD, FlushD, RegWriteW, WriteRegW, ResultW,
           ALUOutM, ForwardAD, ForwardBD,
    output InstrD, PCPlus4D, ValidD, RsD, RtD, RdD, RD1_D, RD2_D, ImmD,
           PCBranchD, PCJumpD, EqualD, BranchTakenD
  );
endinterface

// File: rtl/decode_stage_param.sv
// MiniMIPS decode stage: IF/ID register, resettable register file, operand forwarding,
// immediate extension and BEQ/BNE resolution in D.
module decode_stage_param #(
  parameter int          DATA_WIDTH   = 32,
  parameter bit          ZERO_REG     = 1'b1,
  parameter bit          WRITE_BYPASS = 1'b1,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0000
) (
  input logic                 CLK,
  input logic                 RST,
  decode_stage_param_if.slave bus
);

  localparam int          EXT_W   = DATA_WIDTH - 16;
  localparam logic [5:0]  OP_BEQ  = 6'h04;
  localparam logic [5:0]  OP_BNE  = 6'h05;
  localparam logic [5:0]  OP_ANDI = 6'h0C;
  localparam logic [5:0]  OP_ORI  = 6'h0D;
  localparam logic [5:0]  OP_XORI = 6'h0E;

  logic [31:0]           instr_d;
  logic [DATA_WIDTH-1:0] pcplus4_d;
  logic                  valid_d;
  logic [DATA_WIDTH-1:0] rf [32];
  logic [4:0]            rs, rt;
  logic [5:0]            op;
  logic [DATA_WIDTH-1:0] rf_rs, rf_rt;
  logic [DATA_WIDTH-1:0] rd1, rd2;
  logic [DATA_WIDTH-1:0] simm, imm;
  logic                  equal;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      instr_d   <= NOP_INSTR;
      pcplus4_d <= '0;
      valid_d   <= 1'b0;
    end else if (bus.FlushD) begin
      instr_d   <= NOP_INSTR;
      pcplus4_d <= '0;
      valid_d   <= 1'b0;
    end else if (!bus.StallD) begin
      instr_d   <= bus.InstrF;
      pcplus4_d <= bus.PCPlus4F;
      valid_d   <= 1'b1;
    end
  end

  // Entry 0 is never written when ZERO_REG is set, so it stays at its reset value of 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (bus.RegWriteW && !(ZERO_REG && bus.WriteRegW == 5'd0)) begin
      rf[bus.WriteRegW] <= bus.ResultW;
    end
  end

  assign op = instr_d[31:26];
  assign rs = instr_d[25:21];
  assign rt = instr_d[20:16];

  // Zero-register override is applied last so it also masks the write bypass.
  always_comb begin
    rf_rs = rf[rs];
    if (WRITE_BYPASS && bus.RegWriteW && bus.WriteRegW == rs) rf_rs = bus.ResultW;
    if (ZERO_REG && rs == 5'd0) rf_rs = '0;
  end

  always_comb begin
    rf_rt = rf[rt];
    if (WRITE_BYPASS && bus.RegWriteW && bus.WriteRegW == rt) rf_rt = bus.ResultW;
    if (ZERO_REG && rt == 5'd0) rf_rt = '0;
  end

  always_comb begin
    rd1 = rf_rs;
    case (bus.ForwardAD)
      2'b01:   rd1 = bus.ALUOutM;
      2'b10:   rd1 = bus.ResultW;
      default: rd1 = rf_rs;
    endcase
  end

  always_comb begin
    rd2 = rf_rt;
    case (bus.ForwardBD)
      2'b01:   rd2 = bus.ALUOutM;
      2'b10:   rd2 = bus.ResultW;
      default: rd2 = rf_rt;
    endcase
  end

  assign simm  = {{EXT_W{instr_d[15]}}, instr_d[15:0]};
  assign imm   = (op == OP_ANDI || op == OP_ORI || op == OP_XORI)
                 ? {{EXT_W{1'b0}}, instr_d[15:0]} : simm;
  assign equal = (rd1 == rd2);

  assign bus.InstrD       = instr_d;
  assign bus.PCPlus4D     = pcplus4_d;
  assign bus.ValidD       = valid_d;
  assign bus.RsD          = rs;
  assign bus.RtD          = rt;
  assign bus.RdD          = instr_d[15:11];
  assign bus.RD1_D        = rd1;
  assign bus.RD2_D        = rd2;
  assign bus.ImmD         = imm;
  assign bus.PCBranchD    = pcplus4_d + (simm << 2);
  assign bus.PCJumpD      = {pcplus4_d[DATA_WIDTH-1:28], instr_d[25:0], 2'b00};
  assign bus.EqualD       = equal;
  assign bus.BranchTakenD = valid_d & (((op == OP_BEQ) & equal) | ((op == OP_BNE) & ~equal));

endmodule

// File: tb/tb_decode_stage_param.sv
// Directed bench for decode_stage_param; expectations queued when stimulus is driven,
// popped and compared when outputs are sampled. A second instance runs without write bypass.
module tb_decode_stage_param;

  logic CLK;
  logic RST;

  decode_stage_param_if #(.DATA_WIDTH(32)) dif ();
  decode_stage_param_if #(.DATA_WIDTH(32)) bif ();

  decode_stage_param #(.DATA_WIDTH(32), .ZERO_REG(1'b1), .WRITE_BYPASS(1'b1)) dut (
    .CLK(CLK), .RST(RST), .bus(dif.slave)
  );

  decode_stage_param #(.DATA_WIDTH(32), .ZERO_REG(1'b1), .WRITE_BYPASS(1'b0)) dut_nb (
    .CLK(CLK), .RST(RST), .bus(bif.slave)
  );

  assign bif.InstrF    = dif.InstrF;
  assign bif.PCPlus4F  = dif.PCPlus4F;
  assign bif.StallD    = dif.StallD;
  assign bif.FlushD    = dif.FlushD;
  assign bif.RegWriteW = dif.RegWriteW;
  assign bif.WriteRegW = dif.WriteRegW;
  assign bif.ResultW   = dif.ResultW;
  assign bif.ALUOutM   = dif.ALUOutM;
  assign bif.ForwardAD = dif.ForwardAD;
  assign bif.ForwardBD = dif.ForwardBD;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [31:0] BEQ_1_2_P4  = 32'h1022_0004;
  localparam logic [31:0] BEQ_1_2_M1  = 32'h1022_FFFF;
  localparam logic [31:0] BNE_1_2_M1  = 32'h1422_FFFF;
  localparam logic [31:0] ADDI_5_3_N  = 32'h2065_8000;
  localparam logic [31:0] ORI_6_4_N   = 32'h3486_8000;

  string       tag_q[$];
  logic [31:0] val_q[$];
  int          n_total = 0;
  int          n_pass  = 0;

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic got(input logic [31:0] o);
    string       t;
    logic [31:0] e;
    n_total++;
    if (tag_q.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%h expected=<none>", o);
    end else begin
      t = tag_q.pop_front();
      e = val_q.pop_front();
      assert (o === e) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] v);
    dif.RegWriteW = 1'b1;
    dif.WriteRegW = a;
    dif.ResultW   = v;
    step();
    dif.RegWriteW = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST           = 1'b0;
    dif.InstrF    = '0;
    dif.PCPlus4F  = '0;
    dif.StallD    = 1'b0;
    dif.FlushD    = 1'b0;
    dif.RegWriteW = 1'b0;
    dif.WriteRegW = '0;
    dif.ResultW   = '0;
    dif.ALUOutM   = '0;
    dif.ForwardAD = 2'b00;
    dif.ForwardBD = 2'b00;
    #1 RST = 1'b1;

    // Reset state
    expect_val("rst_instr", 32'h0);
    expect_val("rst_valid", 32'h0);
    expect_val("rst_pc4", 32'h0);
    expect_val("rst_rd1", 32'h0);
    expect_val("rst_equal", 32'h1);
    expect_val("rst_taken", 32'h0);
    expect_val("rst_pcbr", 32'h0);
    expect_val("rst_pcj", 32'h0);
    expect_val("rst_imm", 32'h0);
    #1;
    got(dif.InstrD);
    got({31'b0, dif.ValidD});
    got(dif.PCPlus4D);
    got(dif.RD1_D);
    got({31'b0, dif.EqualD});
    got({31'b0, dif.BranchTakenD});
    got(dif.PCBranchD);
    got(dif.PCJumpD);
    got(dif.ImmD);

    // Load BEQ $1,$2,+4 at PC+4 = 0x100; regs are 0 so the branch is taken
    dif.InstrF   = BEQ_1_2_P4;
    dif.PCPlus4F = 32'h100;
    RST          = 1'b0;
    expect_val("load_instr", BEQ_1_2_P4);
    expect_val("load_valid", 32'h1);
    expect_val("load_pc4", 32'h100);
    expect_val("load_rs", 32'd1);
    expect_val("load_rt", 32'd2);
    expect_val("load_taken", 32'h1);
    expect_val("load_pcbr", 32'h110);
    step();
    got(dif.InstrD);
    got({31'b0, dif.ValidD});
    got(dif.PCPlus4D);
    got({27'b0, dif.RsD});
    got({27'b0, dif.RtD});
    got({31'b0, dif.BranchTakenD});
    got(dif.PCBranchD);

    // Stall two cycles with new fetch data present
    dif.InstrF   = 32'hFFFF_FFFF;
    dif.PCPlus4F = 32'h104;
    dif.StallD   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      expect_val("stall_instr", BEQ_1_2_P4);
      expect_val("stall_pc4", 32'h100);
      step();
      got(dif.InstrD);
      got(dif.PCPlus4D);
    end

    // Flush wins over stall
    dif.FlushD = 1'b1;
    expect_val("flush_instr", 32'h0);
    expect_val("flush_valid", 32'h0);
    expect_val("flush_taken", 32'h0);
    expect_val("flush_pc4", 32'h0);
    step();
    got(dif.InstrD);
    got({31'b0, dif.ValidD});
    got({31'b0, dif.BranchTakenD});
    got(dif.PCPlus4D);
    dif.FlushD = 1'b0;
    dif.StallD = 1'b0;

    // Zero register: read $0 while writing 0x55 to it, then after the dropped write
    dif.InstrF = 32'h0;
    step();
    dif.RegWriteW = 1'b1;
    dif.WriteRegW = 5'd0;
    dif.ResultW   = 32'h55;
    dif.StallD    = 1'b1;
    expect_val("zero_bypass_rd1", 32'h0);
    #1;
    got(dif.RD1_D);
    step();
    dif.RegWriteW = 1'b0;
    expect_val("zero_rd1", 32'h0);
    expect_val("zero_rd1_nb", 32'h0);
    #1;
    got(dif.RD1_D);
    got(bif.RD1_D);
    dif.StallD = 1'b0;

    // Write bypass: ADDI reading $3 while $3 is written in the same cycle
    dif.InstrF = ADDI_5_3_N;
    step();
    dif.StallD    = 1'b1;
    dif.RegWriteW = 1'b1;
    dif.WriteRegW = 5'd3;
    dif.ResultW   = 32'hDEAD_BEEF;
    expect_val("bypass_rd1", 32'hDEAD_BEEF);
    expect_val("nobypass_rd1", 32'h0);
    expect_val("addi_imm", 32'hFFFF_8000);
    #1;
    got(dif.RD1_D);
    got(bif.RD1_D);
    got(dif.ImmD);
    step();
    dif.RegWriteW = 1'b0;
    expect_val("bypass_rd1_next", 32'hDEAD_BEEF);
    expect_val("nobypass_rd1_next", 32'hDEAD_BEEF);
    #1;
    got(dif.RD1_D);
    got(bif.RD1_D);
    dif.StallD = 1'b0;

    // Forwarding: $4 = 1, ALUOutM = 7, ResultW = 9
    write_reg(5'd4, 32'd1);
    dif.InstrF = ORI_6_4_N;
    step();
    dif.StallD  = 1'b1;
    dif.ALUOutM = 32'd7;
    dif.ResultW = 32'd9;
    expect_val("ori_imm", 32'h0000_8000);
    #1;
    got(dif.ImmD);
    begin
      logic [1:0]  fcode [4];
      logic [31:0] fexp  [4];
      fcode = '{2'b00, 2'b01, 2'b10, 2'b11};
      fexp  = '{32'd1, 32'd7, 32'd9, 32'd1};
      for (int i = 0; i < 4; i++) begin
        dif.ForwardAD = fcode[i];
        expect_val("fwd_a", fexp[i]);
        #1;
        got(dif.RD1_D);
      end
    end
    dif.ForwardAD = 2'b00;
    dif.ForwardBD = 2'b01;
    expect_val("fwd_b_alu", 32'd7);
    #1;
    got(dif.RD2_D);
    dif.ForwardBD = 2'b00;
    dif.StallD    = 1'b0;

    // Branch: $1 = $2 = 5, BEQ imm = 0xFFFF at PC+4 = 0x200
    write_reg(5'd1, 32'd5);
    write_reg(5'd2, 32'd5);
    dif.InstrF   = BEQ_1_2_M1;
    dif.PCPlus4F = 32'h200;
    expect_val("beq_equal", 32'h1);
    expect_val("beq_taken", 32'h1);
    expect_val("beq_pcbr", 32'h1FC);
    expect_val("beq_pcj", 32'h008B_FFFC);
    step();
    got({31'b0, dif.EqualD});
    got({31'b0, dif.BranchTakenD});
    got(dif.PCBranchD);
    got(dif.PCJumpD);

    dif.InstrF = BNE_1_2_M1;
    expect_val("bne_taken_eq", 32'h0);
    step();
    got({31'b0, dif.BranchTakenD});
    dif.ALUOutM   = 32'd7;
    dif.ForwardAD = 2'b01;
    expect_val("bne_equal_fwd", 32'h0);
    expect_val("bne_taken_fwd", 32'h1);
    #1;
    got({31'b0, dif.EqualD});
    got({31'b0, dif.BranchTakenD});
    dif.ForwardAD = 2'b00;

    // Asynchronous reset between edges
    #2;
    RST = 1'b1;
    expect_val("arst_valid", 32'h0);
    expect_val("arst_instr", 32'h0);
    expect_val("arst_taken", 32'h0);
    #1;
    got({31'b0, dif.ValidD});
    got(dif.InstrD);
    got({31'b0, dif.BranchTakenD});
    RST = 1'b0;

    // Regfile cleared by that reset: $1, $2 and $3 read as 0
    dif.InstrF = BEQ_1_2_M1;
    expect_val("arst_rd1", 32'h0);
    expect_val("arst_rd2", 32'h0);
    expect_val("arst_valid_after", 32'h1);
    step();
    got(dif.RD1_D);
    got(dif.RD2_D);
    got({31'b0, dif.ValidD});
    dif.InstrF = ADDI_5_3_N;
    expect_val("arst_r3", 32'h0);
    expect_val("arst_r3_nb", 32'h0);
    step();
    got(dif.RD1_D);
    got(bif.RD1_D);

    n_total++;
    assert (tag_q.size() == 0) n_pass++;
    else $error("FAIL scoreboard_leftover observed=%0d expected=0", tag_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_stage_param.md
Name: decode_stage_param

Overview:
Parameterised next-generation decode stage for the 5-stage MiniMIPS pipeline. It absorbs the IF/ID pipeline register, with stall, flush and valid tracking, and contains a reset-clearable register file with optional write-through bypass. It also provides 3-way operand forwarding and resolves BEQ/BNE in the decode stage with zero- or sign-extension selected by opcode. It sits between the fetch stage and the ID/EX register and drives the hazard unit and the PC-select logic.

Parameters:
DATA_WIDTH, 32, datapath width; must be >= 32; immediates and targets extend to this width
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes
WRITE_BYPASS, 1, 1 = same-cycle W-stage write is visible on RD1/RD2 reads
NOP_INSTR, 32'h0000_0000, instruction value loaded into IF/ID on reset or flush

Ports:
CLK  in  1  rising-edge clock
RST  in  1  asynchronous, active-high reset
InstrF  in  32  fetched instruction
PCPlus4F  in  DATA_WIDTH  fetch PC+4
StallD  in  1  hold IF/ID contents
FlushD  in  1  replace IF/ID contents with NOP, valid=0
RegWriteW  in  1  register-file write enable
WriteRegW  in  5  write address
ResultW  in  DATA_WIDTH  write data
ALUOutM  in  DATA_WIDTH  M-stage forward source
ForwardAD  in  2  Rs source: 00 regfile, 01 ALUOutM, 10 ResultW, 11 regfile
ForwardBD  in  2  Rt source, same encoding as ForwardAD
InstrD  out  32  registered instruction
PCPlus4D  out  DATA_WIDTH  registered PC+4
ValidD  out  1  IF/ID holds a live instruction
RsD, RtD, RdD  out  5 each  InstrD[25:21], [20:16], [15:11]
RD1_D, RD2_D  out  DATA_WIDTH  forwarded operands
ImmD  out  DATA_WIDTH  extended immediate
PCBranchD  out  DATA_WIDTH  PCPlus4D + (sign-extended imm << 2)
PCJumpD  out  DATA_WIDTH  {PCPlus4D[DATA_WIDTH-1:28], InstrD[25:0], 2'b00}
EqualD  out  1  RD1_D == RD2_D
BranchTakenD  out  1  taken BEQ/BNE

Behaviour:
- IF/ID register:
  - RST asserted: InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0, asynchronously.
  - On each rising edge, priority is FlushD > StallD > load.
  - FlushD=1: InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0.
  - StallD=1 (FlushD=0): all three hold.
  - Otherwise: load InstrF and PCPlus4F, ValidD=1.
- Register file:
  - 32 x DATA_WIDTH; all entries cleared asynchronously on RST.
  - Written on the rising edge when RegWriteW=1.
  - ZERO_REG=1: writes to address 0 are dropped and reads of address 0 return 0.
  - Reads are combinational on RsD/RtD.
  - WRITE_BYPASS=1: when RegWriteW=1 and WriteRegW equals the read address (and is not 0 with ZERO_REG=1), the read returns ResultW in the same cycle.
  - WRITE_BYPASS=0: the value appears the cycle after the write.
- Forwarding: mux per the ForwardAD/ForwardBD encoding; code 11 selects the regfile value.
- Immediate:
  - Opcodes 0x0C, 0x0D, 0x0E (ANDI/ORI/XORI) zero-extend InstrD[15:0].
  - All other opcodes sign-extend.
  - PCBranchD always uses sign extension, regardless of opcode.
- Arithmetic wraps modulo 2^DATA_WIDTH; there is no overflow flag.
- Branch: BranchTakenD = ValidD & ((op==0x04 & EqualD) | (op==0x05 & ~EqualD)). It is purely combinational, so branch latency is 0 cycles within D.
- All D outputs are combinational functions of the IF/ID register, the regfile and the forwarding inputs.
- With ValidD=0, BranchTakenD=0 regardless of the operands.
- Reset values, derived from the cleared state:
  - InstrD=NOP_INSTR, ValidD=0, PCPlus4D=0.
  - RsD/RtD/RdD are the corresponding fields of NOP_INSTR (all 0 for the default).
  - RD1_D=RD2_D=0, EqualD=1, BranchTakenD=0, PCBranchD=PCJumpD=0, ImmD=0 (for the default NOP_INSTR).
- RST mid-operation clears the IF/ID register and the entire regfile immediately, without waiting for CLK.

Test Plan:
- Load/stall/flush: load BEQ $1,$2,+4 at PC+4=0x100. Assert StallD for 2 cycles, then FlushD and StallD together -> InstrD holds during the stall; after the flush InstrD=0, ValidD=0, BranchTakenD=0.
- Write bypass: with RegWriteW=1, WriteRegW=3, ResultW=0xDEADBEEF, and InstrD reading Rs=3 in the same cycle -> RD1_D=0xDEADBEEF in that cycle; with WRITE_BYPASS=0 -> RD1_D=0 in that cycle, 0xDEADBEEF the next.
- Zero register: write 0x55 to register 0, then read Rs=0 -> RD1_D=0.
- Forwarding: regfile $4=1, ALUOutM=7, ResultW=9. ForwardAD=00/01/10/11 -> RD1_D=1/7/9/1.
- Branch: $1=$2=5 with BEQ, imm=0xFFFF, PCPlus4D=0x200 -> EqualD=1, BranchTakenD=1, PCBranchD=0x1FC. Same operands with BNE -> BranchTakenD=0.
- Immediate and reset: ORI imm=0x8000 -> ImmD=0x00008000; ADDI imm=0x8000 -> ImmD=0xFFFF8000. Assert RST between clock edges -> ValidD=0 and all regfile reads return 0 immediately.
